// File: rtl/wr_req_arbiter.sv
// Slave-side write-request arbiter: merges the two master write requests
// aimed at one slave into one registered request. Round-robin grant held
// until the slave acks or an optional timeout aborts the transfer.
module wr_req_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m0_req,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  input  logic              i_m1_req,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic              o_s_req,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_wdata,
  output logic              o_s_mid,
  input  logic              i_s_ack
);

  // Counter only needs to reach TIMEOUT_CYC-1; with timeout disabled it
  // just wraps harmlessly.
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_s_req;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wdata;
  logic              r_s_mid;
  logic              r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;

  logic w_pick;
  logic w_tmo;

  // Winner select: contention goes to the master that did not win last;
  // otherwise whichever master is requesting (m1 iff only m1 requests).
  always_comb begin
    w_pick = 1'b0;
    if (i_m0_req && i_m1_req) w_pick = ~r_last;
    else                      w_pick = i_m1_req;
    w_tmo = (TIMEOUT_CYC > 0) && (r_cnt == LAST_CNT);
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_s_req   <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_mid   <= 1'b0;
      r_m0_ack  <= 1'b0;
      r_m0_err  <= 1'b0;
      r_m1_ack  <= 1'b0;
      r_m1_err  <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m1_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_m0_req || i_m1_req) begin
            r_s_req   <= 1'b1;
            r_s_mid   <= w_pick;
            r_s_addr  <= w_pick ? i_m1_addr  : i_m0_addr;
            r_s_wdata <= w_pick ? i_m1_wdata : i_m0_wdata;
            r_cnt     <= '0;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Ack has priority over a coincident timeout.
          if (i_s_ack) begin
            r_s_req  <= 1'b0;
            r_m0_ack <= ~r_s_mid;
            r_m1_ack <= r_s_mid;
            r_last   <= r_s_mid;
            r_state  <= ST_DONE;
          end else if (w_tmo) begin
            r_s_req  <= 1'b0;
            r_m0_err <= ~r_s_mid;
            r_m1_err <= r_s_mid;
            r_last   <= r_s_mid;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // One dead cycle so the winner can drop req after seeing ack/err.
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_s_req   = r_s_req;
  assign o_s_addr  = r_s_addr;
  assign o_s_wdata = r_s_wdata;
  assign o_s_mid   = r_s_mid;
  assign o_m0_ack  = r_m0_ack;
  assign o_m0_err  = r_m0_err;
  assign o_m1_ack  = r_m1_ack;
  assign o_m1_err  = r_m1_err;

endmodule
